// File: rtl/rx_byte_fifo_if.sv
// Byte-stream bus between the UART receiver / consumer and the receive FIFO.
interface rx_byte_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  RD_EN;
  logic                  OVF_CLR;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_VALID;
  logic                  EMPTY;
  logic                  FULL;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  OVERFLOW;

  // receiver + consumer side
  modport master (
    output Data_Valid, P_DATA, RD_EN, OVF_CLR,
    input  RD_DATA, RD_VALID, EMPTY, FULL, COUNT, OVERFLOW
  );

  // FIFO side
  modport slave (
    input  Data_Valid, P_DATA, RD_EN, OVF_CLR,
    output RD_DATA, RD_VALID, EMPTY, FULL, COUNT, OVERFLOW
  );
endinterface

// File: rtl/rx_byte_fifo.sv
// Circular receive FIFO behind the UART receiver. Registered read port with
// one-cycle latency, registered fill level / flags, sticky overflow.
module rx_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic CLK,
  input  logic RST,
  rx_byte_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_q, count_nxt;
  logic                  empty_q, full_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  ovf_q;
  logic                  rd_acc, wr_acc, ovf_evt;

  // A full FIFO still takes a write when a read frees a slot in the same cycle;
  // an empty FIFO never reads, so a same-cycle write does not fall through.
  assign rd_acc  = bus.RD_EN & ~empty_q;
  assign wr_acc  = bus.Data_Valid & (~full_q | rd_acc);
  assign ovf_evt = bus.Data_Valid & full_q & ~rd_acc;

  // next fill level
  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_nxt = count_q - 1'b1;
  end

  // storage: no reset, contents are meaningless until written
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr] <= bus.P_DATA;
  end

  // pointers, fill level and flags
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == CNT_FULL);
    end
  end

  // registered read port; data holds between reads
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem[rd_ptr];
    end
  end

  // sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge CLK) begin
    if (!RST)             ovf_q <= 1'b0;
    else if (ovf_evt)     ovf_q <= 1'b1;
    else if (bus.OVF_CLR) ovf_q <= 1'b0;
  end

  assign bus.RD_DATA  = rd_data_q;
  assign bus.RD_VALID = rd_valid_q;
  assign bus.EMPTY    = empty_q;
  assign bus.FULL     = full_q;
  assign bus.COUNT    = count_q;
  assign bus.OVERFLOW = ovf_q;
endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo with hand-computed expectations.
module tb_rx_byte_fifo;
  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  rx_byte_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  rx_byte_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs sampled 1 ns after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.Data_Valid = 1'b1;
    bus.P_DATA     = b;
    tick();
    bus.Data_Valid = 1'b0;
  endtask

  task automatic rd();
    bus.RD_EN = 1'b1;
    tick();
    bus.RD_EN = 1'b0;
  endtask

  initial begin
    RST            = 1'b0;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = '0;
    bus.RD_EN      = 1'b0;
    bus.OVF_CLR    = 1'b0;
    tick();
    tick();
    RST = 1'b1;

    // reset state
    chk("rst_empty", bus.EMPTY, 1);
    chk("rst_full", bus.FULL, 0);
    chk("rst_count", bus.COUNT, 0);
    chk("rst_ovf", bus.OVERFLOW, 0);
    chk("rst_rdv", bus.RD_VALID, 0);
    chk("rst_rdd", bus.RD_DATA, 8'h00);

    // single byte
    wr(8'hA5);
    chk("one_empty", bus.EMPTY, 0);
    chk("one_count", bus.COUNT, 1);
    rd();
    chk("one_rdv", bus.RD_VALID, 1);
    chk("one_rdd", bus.RD_DATA, 8'hA5);
    tick();
    chk("one_rdv_pulse", bus.RD_VALID, 0);
    chk("one_rdd_hold", bus.RD_DATA, 8'hA5);
    chk("one_count0", bus.COUNT, 0);
    chk("one_empty1", bus.EMPTY, 1);

    // fill and overflow
    for (int i = 1; i <= 8; i++) wr(8'(i));
    chk("fill_full_pre", bus.FULL, 1);
    chk("fill_ovf_pre", bus.OVERFLOW, 0);
    wr(8'hFF);
    chk("fill_full", bus.FULL, 1);
    chk("fill_count", bus.COUNT, 8);
    chk("fill_ovf", bus.OVERFLOW, 1);
    for (int i = 1; i <= 8; i++) begin
      rd();
      chk("fill_rdv", bus.RD_VALID, 1);
      chk("fill_rdd", bus.RD_DATA, 32'(i));
    end
    chk("fill_drained", bus.EMPTY, 1);
    chk("fill_ovf_sticky", bus.OVERFLOW, 1);
    bus.OVF_CLR = 1'b1;
    tick();
    bus.OVF_CLR = 1'b0;
    chk("ovf_clr", bus.OVERFLOW, 0);

    // wrap, simultaneous read+write while full
    for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
    chk("wrap_full", bus.FULL, 1);
    bus.Data_Valid = 1'b1;
    bus.P_DATA     = 8'h55;
    bus.RD_EN      = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    bus.RD_EN      = 1'b0;
    chk("wrap_rdv", bus.RD_VALID, 1);
    chk("wrap_rdd", bus.RD_DATA, 8'h10);
    chk("wrap_ovf", bus.OVERFLOW, 0);
    chk("wrap_count", bus.COUNT, 8);
    chk("wrap_full2", bus.FULL, 1);
    for (int i = 1; i < 8; i++) begin
      rd();
      chk("wrap_drain", bus.RD_DATA, 32'(8'h10 + 8'(i)));
    end
    rd();
    chk("wrap_last", bus.RD_DATA, 8'h55);
    chk("wrap_empty", bus.EMPTY, 1);

    // empty-edge cases
    rd();
    chk("emp_rdv", bus.RD_VALID, 0);
    chk("emp_count", bus.COUNT, 0);
    chk("emp_rdd_hold", bus.RD_DATA, 8'h55);
    bus.Data_Valid = 1'b1;
    bus.P_DATA     = 8'h3C;
    bus.RD_EN      = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    bus.RD_EN      = 1'b0;
    chk("emp_wr_rdv", bus.RD_VALID, 0);
    chk("emp_wr_count", bus.COUNT, 1);
    chk("emp_wr_empty", bus.EMPTY, 0);
    rd();
    chk("emp_rd_rdv", bus.RD_VALID, 1);
    chk("emp_rd_rdd", bus.RD_DATA, 8'h3C);

    // set beats clear, then reset mid-operation
    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
    chk("mid_count5", bus.COUNT, 5);
    for (int i = 5; i < 8; i++) wr(8'hC0 + 8'(i));
    bus.Data_Valid  = 1'b1;
    bus.P_DATA      = 8'hEE;
    bus.OVF_CLR     = 1'b1;
    tick();
    bus.Data_Valid  = 1'b0;
    bus.OVF_CLR     = 1'b0;
    chk("set_wins", bus.OVERFLOW, 1);
    chk("set_count", bus.COUNT, 8);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("mid_count", bus.COUNT, 0);
    chk("mid_empty", bus.EMPTY, 1);
    chk("mid_full", bus.FULL, 0);
    chk("mid_ovf", bus.OVERFLOW, 0);
    chk("mid_rdd", bus.RD_DATA, 8'h00);
    rd();
    chk("mid_rdv", bus.RD_VALID, 0);
    chk("mid_count_after", bus.COUNT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
